echo_line_writer: RTL and testbench
===================================

Name: echo_line_writer

Overview:
Parametrised successor of the post-log echo writer in the receive chain. It takes log-compressed envelope samples for one scan line and smooths them with a configurable boxcar. It subtracts a per-zone noise floor, selects the depth zone that belongs to the current focus, decimates to display resolution and writes the result into an N-bank rotating image buffer. Sits between LOG_Table and the image RAM, in the AD_CLK domain; read-side bank indices are exported for the host-transfer logic.

Parameters:
DATA_W, 8, width of Log_In and WR_Data
AVG_LOG2, 4, boxcar length = 2**AVG_LOG2 (1..5)
NUM_ZONES, 3, number of depth zones / focus settings (2..4)
FOCUS_W, 2, width of Focus_Num
ADDR_W, 9, write address width; line depth = 2**ADDR_W
NUM_BANKS, 4, image banks (power of 2, >=3); BANK_W = log2(NUM_BANKS)
CNT_W, 16, sample counter width

Ports:
AD_CLK  in  1  sample clock
RST  in  1  asynchronous reset, active-high
Frame_Start  in  1  single-cycle pulse, already synchronous to AD_CLK; advances write bank
Line_Valid  in  1  high while Log_In carries the current line
Log_In  in  DATA_W  log-compressed sample
Focus_Num  in  FOCUS_W  focus zone of the current transmit, sampled at line start
Decim  in  8  write one output per Decim+1 accepted samples
Zone_End  in  NUM_ZONES*CNT_W  packed inclusive sample-count end of each zone; zone NUM_ZONES-1 extends to infinity
Noise_Floor  in  NUM_ZONES*DATA_W  packed per-zone floor
WR_En  out  1  RAM write strobe
WR_Addr  out  ADDR_W  RAM address within bank
WR_Bank  out  BANK_W  current write bank
WR_Data  out  DATA_W  smoothed, floored sample
RD_Bank_A  out  BANK_W  WR_Bank-1 mod NUM_BANKS
RD_Bank_B  out  BANK_W  WR_Bank-2 mod NUM_BANKS
Line_Done  out  1  one-cycle pulse on the cycle after Line_Valid falls

Behaviour:
- Reset values: all outputs 0, RD_Bank_A = NUM_BANKS-1, RD_Bank_B = NUM_BANKS-2; state IDLE; delay line and sum cleared.
- States:
  - IDLE: wait for a Line_Valid rising edge.
  - FILL: first 2**AVG_LOG2 samples; the averager warms up and writes are suppressed.
  - RUN: normal operation.
  - FULL: address reached 2**ADDR_W-1 after a write; no further writes until the line ends.
  - Any state -> IDLE on Line_Valid=0, with Line_Done pulsed if the previous state was not IDLE.
- Line start (IDLE->FILL): latch Focus_Num and Decim; clear the sample counter, decimation counter, address, running sum and delay line.
- Averager:
  - Running sum, width DATA_W+AVG_LOG2: sum <= sum + Log_In - oldest.
  - Avg = sum >> AVG_LOG2, registered.
- Zone: smallest z with Sample_Counter <= Zone_End[z], else NUM_ZONES-1. Evaluated in the same pipeline stage as Avg.
- Floor: WR_Data = Avg > Noise_Floor[z] ? Avg - Noise_Floor[z] : 0 (saturating).
- Latency: Log_In accepted at cycle t appears on WR_Data/WR_En at t+2.
- Sample_Counter: counts accepted samples and saturates at 2**CNT_W-1.
- Decimation counter:
  - Counts 0..Decim_latched in RUN.
  - When it equals Decim_latched it returns to 0, WR_En=1 if zone == latched Focus_Num, and the address increments after the write.
  - A write is still counted (address advances) when the zone does not match but WR_En stays 0, so image geometry is identical across focus passes.
- Decim=0: every sample is written.
- Frame_Start advances the bank modulo NUM_BANKS. If it coincides with a write, that write goes to the old bank, and the new bank applies from the next cycle.
- Frame_Start mid-line is legal and does not reset line counters.
- RST mid-line aborts immediately: WR_En drops and no Line_Done pulse is issued.

Decomposition:
- Package echo_pkg: state enum (IDLE/FILL/RUN/FULL); functions to unpack Zone_End/Noise_Floor slices; bank-rotation helper.
- One sub-module: boxcar_avg (delay line + running sum, parameterised on DATA_W/AVG_LOG2), reused later for lateral smoothing.

Test Plan:
- Constant Log_In=100, Floor={10,10,10}, Decim=0, Focus=0, Zone_End={1000,2000,-}, line of 40 samples -> first write at sample 16 with WR_Data=90, WR_Addr 0..23 consecutive, Line_Done one cycle after Line_Valid falls.
- Decim=3, ramp input -> WR_En every 4th cycle; WR_Addr increments by 1 per write; WR_Data equals mean of previous 16 samples minus floor, at t+2.
- Focus=1, Zone_End={20,60,-}, 100-sample line -> WR_En only while the sample counter is in 21..60; address still advances outside, so the first write is at address 5 with Decim=0.
- Log_In=5, Floor=20 -> WR_Data=0 (no wrap); Log_In=255, AVG_LOG2=5 -> sum reaches 8160 with no overflow and WR_Data=255-floor.
- 600-sample line, ADDR_W=9, Decim=0 -> last write at address 511, state FULL, no further WR_En; four Frame_Start pulses -> WR_Bank 1,2,3,0 with RD_Bank_A/B = 0/3, 1/0, 2/1, 3/2.
- RST asserted mid-RUN -> outputs 0 asynchronously, no Line_Done; Frame_Start coinciding with WR_En -> that write carries the old WR_Bank.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo line writer.
// Packed-vector slicing and bank rotation live here.
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FULL
  } state_e;

  localparam int VEC_MAX   = 128;
  localparam int SLICE_MAX = 32;

  // Extract slice idx of width w from a zero-padded packed vector.
  function automatic logic [SLICE_MAX-1:0] get_slice(
    input logic [VEC_MAX-1:0] vec,
    input int                 idx,
    input int                 w
  );
    logic [SLICE_MAX-1:0] mask;
    if (w >= SLICE_MAX) mask = '1;
    else mask = (SLICE_MAX'(1) << w) - SLICE_MAX'(1);
    return SLICE_MAX'(vec >> (idx * w)) & mask;
  endfunction

  // Bank index b moved by d positions around a ring of n banks.
  function automatic int bank_step(
    input int b,
    input int d,
    input int n
  );
    return (b + d + n) % n;
  endfunction

endpackage

// File: rtl/echo_line_writer_boxcar.sv
// Boxcar averager: delay line plus running sum.
// clr_i restarts the window; with en_i the new sample enters it.
module boxcar_avg #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic [DATA_W-1:0]            din_i,
  output logic [DATA_W+AVG_LOG2-1:0]   sum_o
);

  localparam int LEN   = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0] dl_q [LEN];
  logic [DATA_W-1:0] dl_d [LEN];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] oldest;

  // Next window contents and running sum (modulo arithmetic is exact).
  always_comb begin
    oldest = clr_i ? '0 : dl_q[LEN-1];
    sum_d  = clr_i ? '0 : sum_q;
    for (int i = 0; i < LEN; i++) begin
      dl_d[i] = clr_i ? '0 : dl_q[i];
    end
    if (en_i) begin
      sum_d   = sum_d + SUM_W'(din_i) - SUM_W'(oldest);
      dl_d[0] = din_i;
      for (int i = 1; i < LEN; i++) begin
        dl_d[i] = clr_i ? '0 : dl_q[i-1];
      end
    end
  end

  // Window and sum registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
      for (int i = 0; i < LEN; i++) dl_q[i] <= '0;
    end else begin
      sum_q <= sum_d;
      for (int i = 0; i < LEN; i++) dl_q[i] <= dl_d[i];
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/echo_line_writer.sv
// Post-log echo writer: boxcar, zone floor, decimation,
// and rotating image-bank write port.
module echo_line_writer
  import echo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int AVG_LOG2  = 4,
  parameter int NUM_ZONES = 3,
  parameter int FOCUS_W   = 2,
  parameter int ADDR_W    = 9,
  parameter int NUM_BANKS = 4,
  parameter int CNT_W     = 16,
  localparam int BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic                          AD_CLK,
  input  logic                          RST,
  input  logic                          Frame_Start,
  input  logic                          Line_Valid,
  input  logic [DATA_W-1:0]             Log_In,
  input  logic [FOCUS_W-1:0]            Focus_Num,
  input  logic [7:0]                    Decim,
  input  logic [NUM_ZONES*CNT_W-1:0]    Zone_End,
  input  logic [NUM_ZONES*DATA_W-1:0]   Noise_Floor,
  output logic                          WR_En,
  output logic [ADDR_W-1:0]             WR_Addr,
  output logic [BANK_W-1:0]             WR_Bank,
  output logic [DATA_W-1:0]             WR_Data,
  output logic [BANK_W-1:0]             RD_Bank_A,
  output logic [BANK_W-1:0]             RD_Bank_B,
  output logic                          Line_Done
);

  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] FILL_LAST =
    CNT_W'((1 << AVG_LOG2) - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          dec_q, dec_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [FOCUS_W-1:0]  focus_q;
  logic [7:0]          decim_q;
  logic                start, wr_cnt;

  logic                s1_wr_q;
  logic [CNT_W-1:0]    s1_cnt_q;
  logic [ADDR_W-1:0]   s1_addr_q;

  logic [SUM_W-1:0]    sum;
  logic [DATA_W-1:0]   avg;
  logic [FOCUS_W-1:0]  zone;
  logic [DATA_W-1:0]   floor_sel;
  logic [CNT_W-1:0]    zone_end [NUM_ZONES];
  logic [DATA_W-1:0]   nfloor   [NUM_ZONES];

  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [BANK_W-1:0]   bank_q;
  logic                done_q;

  boxcar_avg #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_box (
    .clk_i(AD_CLK),
    .rst_i(RST),
    .clr_i(start),
    .en_i (Line_Valid),
    .din_i(Log_In),
    .sum_o(sum)
  );

  // Line FSM next state, sample/decimation/address counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    addr_d  = addr_q;
    start   = 1'b0;
    wr_cnt  = 1'b0;
    if (!Line_Valid) begin
      state_d = IDLE;
    end else begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      unique case (state_q)
        IDLE: begin
          state_d = FILL;
          start   = 1'b1;
          cnt_d   = CNT_W'(1);
          dec_d   = '0;
          addr_d  = '0;
        end
        FILL: begin
          if (cnt_q == FILL_LAST) state_d = RUN;
        end
        RUN: begin
          if (dec_q == decim_q) begin
            wr_cnt = 1'b1;
            dec_d  = '0;
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == '1) state_d = FULL;
          end else begin
            dec_d = dec_q + 8'd1;
          end
        end
        FULL: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge AD_CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Counters, per-line latches and first pipeline stage.
  always_ff @(posedge AD_CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      dec_q     <= '0;
      addr_q    <= '0;
      focus_q   <= '0;
      decim_q   <= '0;
      s1_wr_q   <= 1'b0;
      s1_cnt_q  <= '0;
      s1_addr_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      addr_q    <= addr_d;
      s1_wr_q   <= wr_cnt;
      s1_cnt_q  <= start ? '0 : cnt_q;
      s1_addr_q <= addr_q;
      if (start) begin
        focus_q <= Focus_Num;
        decim_q <= Decim;
      end
    end
  end

  // Unpack per-zone thresholds and floors.
  always_comb begin
    for (int z = 0; z < NUM_ZONES; z++) begin
      zone_end[z] = CNT_W'(get_slice(
        VEC_MAX'(Zone_End), z, CNT_W));
      nfloor[z]   = DATA_W'(get_slice(
        VEC_MAX'(Noise_Floor), z, DATA_W));
    end
  end

  // Zone of the stage-1 sample: first end it does not exceed.
  always_comb begin
    avg       = DATA_W'(sum >> AVG_LOG2);
    zone      = FOCUS_W'(NUM_ZONES - 1);
    floor_sel = nfloor[NUM_ZONES-1];
    for (int z = NUM_ZONES - 2; z >= 0; z--) begin
      if (s1_cnt_q <= zone_end[z]) begin
        zone      = FOCUS_W'(z);
        floor_sel = nfloor[z];
      end
    end
  end

  // Output stage: floored average and gated write strobe.
  always_ff @(posedge AD_CLK or posedge RST) begin
    if (RST) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q   <= s1_wr_q && (zone == focus_q);
      wr_addr_q <= s1_addr_q;
      wr_data_q <= (avg > floor_sel) ? avg - floor_sel : '0;
      done_q    <= !Line_Valid && (state_q != IDLE);
    end
  end

  // Write bank advances after the current cycle's write.
  always_ff @(posedge AD_CLK or posedge RST) begin
    if (RST) bank_q <= '0;
    else if (Frame_Start)
      bank_q <= BANK_W'(bank_step(int'(bank_q), 1, NUM_BANKS));
  end

  assign WR_En     = wr_en_q;
  assign WR_Addr   = wr_addr_q;
  assign WR_Data   = wr_data_q;
  assign WR_Bank   = bank_q;
  assign Line_Done = done_q;
  assign RD_Bank_A =
    BANK_W'(bank_step(int'(bank_q), -1, NUM_BANKS));
  assign RD_Bank_B =
    BANK_W'(bank_step(int'(bank_q), -2, NUM_BANKS));

endmodule

// File: tb/tb_echo_line_writer.sv
// Bench for echo_line_writer: table of scan lines checked
// cycle by cycle, plus reset, bank and abort sequences.
module tb_echo_line_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        Frame_Start, Line_Valid;
  logic [7:0]  Log_In, Decim;
  logic [1:0]  Focus_Num;
  logic [47:0] Zone_End;
  logic [23:0] Noise_Floor;

  logic       we, we5, ld, ld5;
  logic [8:0] wa, wa5;
  logic [1:0] wb, wb5, ra, ra5, rb, rb5;
  logic [7:0] wd, wd5;

  int total = 0;
  int bad = 0;
  int cur_line = -1;
  int cur_cyc = 0;
  int exp_bank = 0;

  always #5 clk = ~clk;

  echo_line_writer u0 (
    .AD_CLK(clk), .RST(rst), .Frame_Start(Frame_Start),
    .Line_Valid(Line_Valid), .Log_In(Log_In),
    .Focus_Num(Focus_Num), .Decim(Decim),
    .Zone_End(Zone_End), .Noise_Floor(Noise_Floor),
    .WR_En(we), .WR_Addr(wa), .WR_Bank(wb),
    .WR_Data(wd), .RD_Bank_A(ra), .RD_Bank_B(rb),
    .Line_Done(ld)
  );

  echo_line_writer #(.AVG_LOG2(5)) u5 (
    .AD_CLK(clk), .RST(rst), .Frame_Start(Frame_Start),
    .Line_Valid(Line_Valid), .Log_In(Log_In),
    .Focus_Num(Focus_Num), .Decim(Decim),
    .Zone_End(Zone_End), .Noise_Floor(Noise_Floor),
    .WR_En(we5), .WR_Addr(wa5), .WR_Bank(wb5),
    .WR_Data(wd5), .RD_Bank_A(ra5), .RD_Bank_B(rb5),
    .Line_Done(ld5)
  );

  typedef struct {
    int pat;   int base; int len;  int decim; int focus;
    int ze0;   int ze1;  int fl0;  int fl1;   int fl2;
    int fs_at; int n_wr; int fa;   int fd;    int la;
    int n5;    int fd5;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s line=%0d cyc=%0d act=%0d exp=%0d",
               nm, cur_line, cur_cyc, act, exp);
    end
  endtask

  task automatic run_line(input vec_t v);
    int hist[600];
    int nwr, fa, fd, la, nwr5, fd5;
    int k, m, j, z, s, fl, ed, ea;
    logic ee;
    Decim       = 8'(v.decim);
    Focus_Num   = 2'(v.focus);
    Zone_End    = {16'd0, 16'(v.ze1), 16'(v.ze0)};
    Noise_Floor = {8'(v.fl2), 8'(v.fl1), 8'(v.fl0)};
    for (int i = 0; i < v.len; i++)
      hist[i] = (v.pat != 0) ? ((v.base + i) & 255) : v.base;
    nwr = 0; fa = -1; fd = -1; la = -1; nwr5 = 0; fd5 = -1;
    for (int i = 0; i < v.len + 3; i++) begin
      @(posedge clk); #1;
      cur_cyc     = i;
      Line_Valid  = (i < v.len);
      Log_In      = (i < v.len) ? 8'(hist[i]) : 8'd0;
      Frame_Start = (i == v.fs_at);
      @(negedge clk);
      k = i - 2; ee = 1'b0; ed = 0; ea = 0;
      if (k >= 16 && k < v.len) begin
        m = k - 16;
        if (m % (v.decim + 1) == v.decim) begin
          j = m / (v.decim + 1);
          if (j <= 511) begin
            z = (k <= v.ze0) ? 0 : (k <= v.ze1) ? 1 : 2;
            s = 0;
            for (int q = k - 15; q <= k; q++) s += hist[q];
            s  = s / 16;
            fl = (z == 0) ? v.fl0 : (z == 1) ? v.fl1 : v.fl2;
            ed = (s > fl) ? s - fl : 0;
            ea = j;
            ee = (z == v.focus);
          end
        end
      end
      chk("wr_en", int'(we), int'(ee));
      if (ee && we) begin
        chk("wr_data", int'(wd), ed);
        chk("wr_addr", int'(wa), ea);
      end
      chk("line_done", int'(ld), int'(i == v.len + 1));
      chk("wr_bank", int'(wb), exp_bank);
      if (i == v.fs_at) exp_bank = (exp_bank + 1) % 4;
      if (we) begin
        if (nwr == 0) begin fa = int'(wa); fd = int'(wd); end
        la = int'(wa);
        nwr++;
      end
      if (we5) begin
        if (nwr5 == 0) fd5 = int'(wd5);
        nwr5++;
      end
    end
    Frame_Start = 1'b0;
    chk("n_writes", nwr, v.n_wr);
    chk("first_addr", fa, v.fa);
    chk("first_data", fd, v.fd);
    chk("last_addr", la, v.la);
    chk("n_writes_avg32", nwr5, v.n5);
    chk("first_data_avg32", fd5, v.fd5);
  endtask

  int eb[4], era[4], erb[4];

  initial begin
    tbl[0] = '{0, 100, 40, 0, 0, 1000, 2000, 10, 10, 10,
               30, 24, 0, 90, 23, 8, 90};
    tbl[1] = '{1, 0, 40, 3, 0, 1000, 2000, 0, 0, 0,
               -1, 6, 0, 11, 5, 2, 19};
    tbl[2] = '{0, 100, 100, 0, 1, 20, 60, 10, 10, 10,
               -1, 40, 5, 90, 44, 29, 90};
    tbl[3] = '{0, 5, 40, 0, 0, 1000, 2000, 20, 20, 20,
               -1, 24, 0, 0, 23, 8, 0};
    tbl[4] = '{0, 255, 40, 0, 0, 1000, 2000, 10, 10, 10,
               -1, 24, 0, 245, 23, 8, 245};
    tbl[5] = '{0, 200, 600, 0, 0, 1000, 2000, 0, 0, 0,
               -1, 512, 0, 200, 511, 512, 200};
    tbl[6] = '{1, 50, 80, 0, 2, 30, 50, 5, 10, 40,
               -1, 29, 35, 53, 63, 29, 45};
    eb  = '{1, 2, 3, 0};
    era = '{0, 1, 2, 3};
    erb = '{3, 0, 1, 2};

    rst = 1'b1; Frame_Start = 1'b0; Line_Valid = 1'b0;
    Log_In = '0; Decim = '0; Focus_Num = '0;
    Zone_End = '0; Noise_Floor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", int'(we), 0);
    chk("rst_wr_addr", int'(wa), 0);
    chk("rst_wr_data", int'(wd), 0);
    chk("rst_wr_bank", int'(wb), 0);
    chk("rst_rd_a", int'(ra), 3);
    chk("rst_rd_b", int'(rb), 2);
    chk("rst_line_done", int'(ld), 0);
    chk("rst_rd_a_avg32", int'(ra5), 3);
    chk("rst_rd_b_avg32", int'(rb5), 2);
    chk("rst_bank_avg32", int'(wb5), 0);
    chk("rst_addr_avg32", int'(wa5), 0);
    chk("rst_done_avg32", int'(ld5), 0);

    for (int p = 0; p < 4; p++) begin
      @(posedge clk); #1 Frame_Start = 1'b1;
      @(posedge clk); #1 Frame_Start = 1'b0;
      @(negedge clk);
      cur_cyc = p;
      chk("bank_wr", int'(wb), eb[p]);
      chk("bank_rd_a", int'(ra), era[p]);
      chk("bank_rd_b", int'(rb), erb[p]);
    end
    exp_bank = 0;

    for (int n = 0; n < 7; n++) begin
      cur_line = n;
      run_line(tbl[n]);
    end

    cur_line = 100;
    Decim = 8'd0; Focus_Num = 2'd0;
    Zone_End = {16'd0, 16'd2000, 16'd1000};
    Noise_Floor = {8'd10, 8'd10, 8'd10};
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      cur_cyc = i;
      Line_Valid = 1'b1; Log_In = 8'd100;
    end
    @(negedge clk);
    chk("abort_pre_wr_en", int'(we), 1);
    chk("abort_pre_bank", int'(wb), 1);
    #2 rst = 1'b1; Line_Valid = 1'b0;
    #1;
    chk("abort_wr_en", int'(we), 0);
    chk("abort_wr_addr", int'(wa), 0);
    chk("abort_wr_data", int'(wd), 0);
    chk("abort_wr_bank", int'(wb), 0);
    chk("abort_rd_a", int'(ra), 3);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cur_cyc = i;
      chk("abort_line_done", int'(ld), 0);
      chk("abort_wr_en_after", int'(we), 0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
